// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - fetch-stage PC sequencer with req/ack memory port and redirect drain
// Optional feature macro: MISALIGN_TRAP_EN (redirects with target bit 1 set trap to TRAP_VEC)
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [1:0]  PCSrc,
  input  logic        BranchValid,
  input  logic [31:0] PCTarget,
  input  logic [31:0] ALUResult,
  input  logic        Stall,
  output logic        IReq,
  output logic [31:0] IAddr,
  input  logic        IAck,
  input  logic [31:0] IData,
  output logic [31:0] Instr,
  output logic [31:0] InstrPC,
  output logic        InstrValid,
  output logic        Flush,
  output logic        Misaligned
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        valid_q, valid_d;
  logic        flush_q, flush_d;
  logic        mis_q, mis_d;

  logic        redirect;
  logic [31:0] jalr_tgt;
  logic [31:0] target;
  logic        mis_hit;
  logic [31:0] redir_pc;

  assign redirect = BranchValid && (PCSrc == 2'b01 || PCSrc == 2'b10);
  assign jalr_tgt = ALUResult & ~32'h1;
  assign target   = (PCSrc == 2'b01) ? PCTarget : jalr_tgt;

`ifdef MISALIGN_TRAP_EN
  assign mis_hit = target[1];
`else
  assign mis_hit = 1'b0;
`endif

  assign redir_pc = mis_hit ? TRAP_VEC : target;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    flush_d    = 1'b0;
    mis_d      = 1'b0;

    if (valid_q && !Stall) valid_d = 1'b0;

    case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: begin
        if (IAck) begin
          instr_d    = IData;
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
          pc_d       = pc_q + 32'd4;
          state_d    = Stall ? HOLD : FETCH;
        end
      end
      HOLD:  if (!Stall) state_d = FETCH;
      DRAIN: if (IAck) state_d = FETCH;
      default: state_d = IDLE;
    endcase

    // A request already on the bus cannot be retracted, so a redirect without
    // its ack parks the old address in DRAIN until memory answers.
    if (redirect) begin
      pc_d       = redir_pc;
      valid_d    = 1'b0;
      instr_d    = NOP_INSTR;
      instr_pc_d = instr_pc_q;
      flush_d    = 1'b1;
      mis_d      = mis_hit;
      case (state_q)
        FETCH: begin
          if (IAck) begin
            state_d = FETCH;
          end else begin
            state_d    = DRAIN;
            req_addr_d = pc_q;
          end
        end
        DRAIN:   state_d = IAck ? FETCH : DRAIN;
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      instr_q    <= NOP_INSTR;
      instr_pc_q <= 32'h0;
      valid_q    <= 1'b0;
      flush_q    <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      flush_q    <= flush_d;
      mis_q      <= mis_d;
    end
  end

  assign IReq       = (state_q == FETCH) || (state_q == DRAIN);
  assign IAddr      = (state_q == DRAIN) ? req_addr_q : pc_q;
  assign Instr      = instr_q;
  assign InstrPC    = instr_pc_q;
  assign InstrValid = valid_q;
  assign Flush      = flush_q;
  assign Misaligned = mis_q;

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Fetch-stage sequencer for the RISC-V core. It owns the program counter and issues requests to instruction memory over a req/ack handshake. It presents fetched instructions downstream with a valid/stall handshake. It applies redirects from the PC-source decoder (PCSrc) and drops any in-flight fetch that a redirect has made stale.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, value driven on Instr while no valid instruction (addi x0,x0,0)
TRAP_VEC, 32'h0000_0100, misaligned-target trap address (used only with MISALIGN_TRAP_EN)

Ports:
CLK  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
PCSrc  in  2  from PC decoder: 00 PC+4, 01 PCTarget (jal/taken branch), 10 ALUResult (jalr), 11 reserved
BranchValid  in  1  PCSrc/targets valid this cycle (EX resolution)
PCTarget  in  32  PC+Imm target
ALUResult  in  32  jalr target; bit 0 is forced to 0
Stall  in  1  downstream cannot accept Instr this cycle
IReq  out  1  instruction-memory request
IAddr  out  32  request address
IAck  in  1  memory response valid; IData valid the same cycle
IData  in  32  instruction word
Instr  out  32  fetched instruction
InstrPC  out  32  address of Instr
InstrValid  out  1  Instr/InstrPC valid
Flush  out  1  one-cycle pulse: younger pipeline stages must squash
Misaligned  out  1  one-cycle pulse on misaligned redirect (MISALIGN_TRAP_EN only; else tied 0)

Behaviour:
- Reset (async): PC=RESET_PC, state IDLE, IReq=0, IAddr=RESET_PC, Instr=NOP_INSTR, InstrPC=0, InstrValid=0, Flush=0, Misaligned=0.
- Redirect: BranchValid=1 and PCSrc in {01,10}. PCSrc=00 or 11 with BranchValid=1 has no effect. Redirect has priority over Stall and over IAck.
- States:
  - IDLE: goes to FETCH on the first clock after Reset deasserts.
  - FETCH: IReq=1, IAddr=PC. IAddr stays stable until IAck.
    - IAck without redirect: registers Instr=IData, InstrPC=PC, InstrValid=1, PC<=PC+4. Next state is FETCH if Stall=0, else HOLD.
  - HOLD: IReq=0. Instr, InstrPC and InstrValid hold. Returns to FETCH the cycle after Stall=0.
  - DRAIN: IReq=1 with the old IAddr until IAck. That IData is discarded. Then goes to FETCH at the new PC.
- Consumption: an instruction is consumed on a cycle where InstrValid=1 and Stall=0. InstrValid clears the next cycle unless a new IAck arrives.
- Redirect handling, all registered at the clock edge:
  - PC<=target. The target is PCTarget, or {ALUResult[31:1],1'b0}.
  - InstrValid<=0, Instr<=NOP_INSTR, Flush<=1 for exactly one cycle.
  - In FETCH without IAck: goes to DRAIN. The outstanding request must complete and is not retracted.
  - In FETCH with IAck in the same cycle: IData is discarded and the next state is FETCH.
  - In HOLD or IDLE: goes to FETCH.
- Redirect during DRAIN: updates PC again (last wins), pulses Flush again, stays in DRAIN.
- Arithmetic: PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0). No overflow flag.
- Latency: a request issued the cycle after FETCH entry gives Instr one cycle after IAck. A redirect gives IAddr=target at least one cycle later (immediately if no fetch is outstanding).
- Reset mid-transaction: all state is discarded. A late IAck in IDLE is ignored.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: on a redirect whose target has bit 1 set (target[1:0]!=0 after masking bit 0):
  - PC<=TRAP_VEC instead of the target;
  - Misaligned pulses for one cycle together with Flush;
  - other redirect rules are unchanged.
- Undefined: targets are used as-is and Misaligned is constant 0.

Test Plan:
- Reset, IAck returned one cycle after each IReq, Stall=0 -> IAddr sequence 0x0,0x4,0x8; Instr equals each IData with matching InstrPC; Flush stays 0.
- Stall=1 for 3 cycles after IAck at PC 0x8 -> HOLD; Instr/InstrPC=0x8 stable, IReq=0; after Stall=0, next IAddr=0xC.
- BranchValid=1, PCSrc=01, PCTarget=0x40 while a request to 0x10 is outstanding -> Flush pulses once, InstrValid=0, late IData for 0x10 dropped, next IAddr=0x40.
- BranchValid=1, PCSrc=10, ALUResult=0x81 in the same cycle as IAck -> IData discarded, next IAddr=0x80.
- PC=0xFFFF_FFFC fetched -> next IAddr=0x0. BranchValid=1 with PCSrc=00 -> no Flush, sequence unchanged.
- With MISALIGN_TRAP_EN: PCSrc=01, PCTarget=0x42 -> Misaligned and Flush pulse, next IAddr=TRAP_VEC (0x100). Without the macro: next IAddr=0x42, Misaligned=0.
